// File: rtl/clkdiv_n.sv
// Programmable clock divider: Y divides CLK by a runtime ratio with glitch-free ratio, polarity and enable changes.
// Outputs are registered one CLK edge after the inputs are sampled; there is no backpressure.
module clkdiv_n #(
  parameter int WIDTH   = 4,
  parameter int RST_DIV = 2
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             EN,
  input  logic             INV,
  input  logic [WIDTH-1:0] DIV,
  input  logic             LD,
  output logic             Y,
  output logic             TICK,
  output logic             ACT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] RST_NA = WIDTH'(RST_DIV);
  localparam logic [WIDTH-1:0] MIN_NA = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] na, na_nxt;
  logic [WIDTH-1:0] np, np_nxt;
  logic             pf, pf_nxt;
  logic             iq, iq_nxt;
  logic             y_nxt, tick_nxt, act_nxt;
  logic             boundary, apply;
  logic [WIDTH-1:0] div_legal;
  logic [WIDTH:0]   half;
  logic             phase;

  assign boundary  = (state != IDLE) && (cnt == na - ONE);
  assign div_legal = (DIV < MIN_NA) ? MIN_NA : DIV;
  // Ratio and polarity only move while idle or on the last cycle of a period,
  // so every pulse on Y is a whole half-period of some ratio.
  assign apply     = (state == IDLE) || boundary;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    na_nxt    = na;
    np_nxt    = np;
    pf_nxt    = pf;
    iq_nxt    = iq;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (EN) state_nxt = RUN;
      end
      RUN: begin
        cnt_nxt = boundary ? '0 : cnt + ONE;
        if (!EN) state_nxt = STOP;
      end
      STOP: begin
        cnt_nxt = boundary ? '0 : cnt + ONE;
        if (EN) state_nxt = RUN;
        else if (boundary) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    if (apply) begin
      if (pf) na_nxt = np;
      pf_nxt = 1'b0;
      iq_nxt = INV;
    end

    // A load on the applying cycle lands in NP after the old NP was consumed.
    if (LD) begin
      np_nxt = div_legal;
      pf_nxt = 1'b1;
    end

    half     = ({1'b0, na_nxt} + (WIDTH+1)'(1)) >> 1;
    phase    = ({1'b0, cnt_nxt} < half);
    act_nxt  = (state_nxt != IDLE);
    y_nxt    = act_nxt ? (phase ^ iq_nxt) : iq_nxt;
    tick_nxt = act_nxt && (cnt_nxt == na_nxt - ONE);
  end

  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      state <= IDLE;
      cnt   <= '0;
      na    <= RST_NA;
      np    <= RST_NA;
      pf    <= 1'b0;
      iq    <= 1'b0;
      Y     <= 1'b0;
      TICK  <= 1'b0;
      ACT   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      na    <= na_nxt;
      np    <= np_nxt;
      pf    <= pf_nxt;
      iq    <= iq_nxt;
      Y     <= y_nxt;
      TICK  <= tick_nxt;
      ACT   <= act_nxt;
    end
  end

endmodule
